fsm4_sequencer: RTL and testbench
=================================

# fsm4_sequencer

Programmable stimulus sequencer for the 2-switch, 4-state machine. It replaces the hand-driven `sw[1:0]` inputs with a stored program of up to four steps, played on a `start` pulse. For each step it applies a switch pattern, holds it for a programmed dwell, then checks the machine's `Q[1:0]` against an expected state. It sits between the board/host control and the state machine's `sw` input, with `Q` fed back for self-checking.

## Interface
- `DWELL_W`, default 8: width of the per-step dwell count in clock cycles.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  program-write strobe; ignored while `busy`=1.
- `wr_addr`  in  2  step index to write (0..3).
- `wr_sw`  in  2  switch pattern for that step.
- `wr_expect`  in  2  expected `Q` at the end of that step.
- `wr_dwell`  in  DWELL_W  hold cycles for that step.
- `len`  in  2  last step index (run covers steps 0..len); sampled on start acceptance.
- `start`  in  1  one-cycle request; accepted only when `busy`=0.
- `abort`  in  1  stops a run in progress.
- `q_in`  in  2  state output `Q` of the 4-state machine.
- `sw_out`  out  2  drives the state machine's `sw`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  sticky: at least one step mismatched in the current/last run.
- `err_step`  out  2  index of the first mismatching step.

## Operation
- Program: 4 entries of {sw, expect, dwell}. A write lands on the edge where `wr_en`=1 and `busy`=0. Reset clears all entries to 0.
- States: IDLE, APPLY, DWELL, CHECK.
- IDLE: `start`=1 → latch `len`, step index `idx`<=0, clear `err`/`err_step`, `busy`<=1, go APPLY.
- APPLY (1 cycle): `sw_out`<=entry[idx].sw, `cnt`<=entry[idx].dwell. Go DWELL if dwell≠0, else CHECK.
- DWELL: `cnt`<=`cnt`-1 each edge. Go CHECK on the edge where `cnt`==1. Lasts exactly dwell cycles.
- CHECK (1 cycle): compare `q_in` with entry[idx].expect. On mismatch with `err`=0, set `err`<=1 and `err_step`<=idx. A mismatch does not stop the run.
  - `idx`==`len` → `busy`<=0, `done`<=1, go IDLE.
  - Otherwise `idx`<=`idx`+1, go APPLY.
- `abort`=1 while busy → IDLE on the next edge, `busy`<=0, no `done`. `abort` has priority over all other transitions.
- `sw_out` holds its last value after completion or abort. Only reset returns it to 00.
- `start` while busy is ignored. `start` and `abort` together in IDLE: `start` wins.

## Timing
- Reset values: `sw_out`=00, `busy`=0, `done`=0, `err`=0, `err_step`=00, state IDLE, all program entries 0.
- Reset mid-run: all of the above apply on the next edge. The program is lost.
- Start accepted at edge k → `busy`=1 after edge k. Step 0's `sw_out` is valid after edge k+1.
- Each step occupies dwell+2 cycles. A run takes Σ(dwell_i+2) cycles from the first APPLY.
- `q_in` is sampled in CHECK, dwell+1 edges after `sw_out` changed.
- Because the state machine registers `Q`, dwell≥1 is required to observe the new state. With dwell=0, CHECK samples the pre-transition `Q`; this is defined behaviour, not an error.
- `done` is high exactly one cycle, coincident with `busy` falling. `done` is not asserted on abort.
- A new `start` is accepted in the cycle `done` is high (FSM already in IDLE).

## Structure
- Package `fsm4_seq_pkg`:
  - state enum.
  - `STEPS`=4 and `IDX_W`=2.
  - step-entry struct {sw[1:0], expect[1:0], dwell[DWELL_W-1:0]}.
- Sub-module `fsm4_seq_prog`: 4-entry register file with synchronous write, asynchronous read by index, and synchronous clear on reset.
- FSM, dwell counter and checker stay in `fsm4_sequencer`.

## Test plan
- Program {sw=01,exp=01,d=2}, {10,10,2}, {11,11,3}, {00,00,1}, `len`=3, `start` with a matching model on `q_in`:
  - `sw_out` steps 01→10→11→00.
  - `done` pulses 4+4+5+3=16 cycles after the first APPLY.
  - `err`=0.
- Same program with the model forcing `q_in`=00 during step 2:
  - `err`=1, `err_step`=2.
  - Run completes and `done` still pulses.
  - Next `start` clears `err`.
- `len`=0, dwell=0: run lasts 2 cycles from APPLY, and CHECK sees the pre-transition `Q`.
- `abort` during step 1 DWELL:
  - `busy` falls next edge, no `done`, `sw_out` holds step 1's pattern.
  - `wr_en` during the run left the program unchanged.
- `reset` asserted mid-step 2: next edge shows `sw_out`=00, `busy`=0, `err`=0. A subsequent `start` without reprogramming drives `sw_out`=00 for all steps.
- `start` held high for 3 cycles and re-asserted during `done`: exactly one run per acceptance, back-to-back runs with no idle gap.

Source files
------------

// File: rtl/fsm4_seq_pkg.sv
// Shared types and constants for the fsm4 stimulus sequencer.
// The stored dwell field is SEQ_DWELL_W wide; the top's DWELL_W defaults to it.
package fsm4_seq_pkg;

  localparam int STEPS       = 4;
  localparam int IDX_W       = 2;
  localparam int SEQ_DWELL_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DWELL = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0]             sw;
    logic [1:0]             exp_q;
    logic [SEQ_DWELL_W-1:0] dwell;
  } step_t;

endpackage

// File: rtl/fsm4_seq_prog.sv
// Four-entry step program: synchronous write, combinational read by step index,
// synchronous clear on reset.
module fsm4_seq_prog
  import fsm4_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       waddr_i,
  input  logic [1:0]             wsw_i,
  input  logic [1:0]             wexp_i,
  input  logic [SEQ_DWELL_W-1:0] wdwell_i,
  input  logic [IDX_W-1:0]       raddr_i,
  output logic [1:0]             rsw_o,
  output logic [1:0]             rexp_o,
  output logic [SEQ_DWELL_W-1:0] rdwell_o
);

  step_t mem_q [STEPS];
  step_t wr_entry_s;
  step_t rd_entry_s;

  assign wr_entry_s = '{sw: wsw_i, exp_q: wexp_i, dwell: wdwell_i};

  // program storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wr_entry_s;
    end
  end

  assign rd_entry_s = mem_q[raddr_i];
  assign rsw_o      = rd_entry_s.sw;
  assign rexp_o     = rd_entry_s.exp_q;
  assign rdwell_o   = rd_entry_s.dwell;

endmodule

// File: rtl/fsm4_sequencer.sv
// Plays a stored program of up to four {sw, expect, dwell} steps into the
// 4-state machine and checks its Q at the end of each step.
module fsm4_sequencer
  import fsm4_seq_pkg::*;
#(
  parameter int DWELL_W = SEQ_DWELL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [1:0]         wr_sw,
  input  logic [1:0]         wr_expect,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [1:0]         len,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         q_in,
  output logic [1:0]         sw_out,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_step
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         sw_q, sw_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   err_step_q, err_step_d;

  logic [1:0]             ent_sw_s;
  logic [1:0]             ent_exp_s;
  logic [SEQ_DWELL_W-1:0] ent_dwell_raw_s;
  logic [DWELL_W-1:0]     ent_dwell_s;

  fsm4_seq_prog u_prog (
    .clk      (clk),
    .reset    (reset),
    .we_i     (wr_en & ~busy_q),
    .waddr_i  (wr_addr),
    .wsw_i    (wr_sw),
    .wexp_i   (wr_expect),
    .wdwell_i (SEQ_DWELL_W'(wr_dwell)),
    .raddr_i  (idx_q),
    .rsw_o    (ent_sw_s),
    .rexp_o   (ent_exp_s),
    .rdwell_o (ent_dwell_raw_s)
  );

  assign ent_dwell_s = DWELL_W'(ent_dwell_raw_s);

  // sequencer state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= {IDX_W{1'b0}};
      len_q      <= {IDX_W{1'b0}};
      cnt_q      <= {DWELL_W{1'b0}};
      sw_q       <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_step_q <= {IDX_W{1'b0}};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      sw_q       <= sw_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_step_q <= err_step_d;
    end
  end

  // next-state: abort pre-empts every busy-state transition
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    sw_d       = sw_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_step_d = err_step_q;

    if (abort && busy_q) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d      = len;
            idx_d      = {IDX_W{1'b0}};
            err_d      = 1'b0;
            err_step_d = {IDX_W{1'b0}};
            busy_d     = 1'b1;
            state_d    = ST_APPLY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_APPLY: begin
          sw_d  = ent_sw_s;
          cnt_d = ent_dwell_s;
          if (ent_dwell_s != {DWELL_W{1'b0}}) begin
            state_d = ST_DWELL;
          end else begin
            state_d = ST_CHECK;
          end
        end
        ST_DWELL: begin
          cnt_d = cnt_q - DWELL_W'(1'b1);
          if (cnt_q == DWELL_W'(1'b1)) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_DWELL;
          end
        end
        ST_CHECK: begin
          // only the first mismatching step of a run is recorded
          if ((q_in != ent_exp_s) && !err_q) begin
            err_d      = 1'b1;
            err_step_d = idx_q;
          end else begin
            err_d      = err_q;
          end
          if (idx_q == len_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1'b1);
            state_d = ST_APPLY;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign sw_out   = sw_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_step = err_step_q;

endmodule

// File: tb/tb_fsm4_sequencer.sv
// Scoreboard bench for fsm4_sequencer: run predictions are queued at start
// acceptance and compared cycle-accurately at the falling clock edge.
module tb_fsm4_sequencer;

  localparam int K_ACC  = 0;
  localparam int K_SW   = 1;
  localparam int K_DONE = 2;

  logic       clk = 1'b0;
  logic       reset, wr_en, start, abort;
  logic [1:0] wr_addr, wr_sw, wr_expect, len, q_in;
  logic [7:0] wr_dwell;
  logic [1:0] sw_out, err_step;
  logic       busy, done, err;

  always #5 clk = ~clk;

  fsm4_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sw(wr_sw),
    .wr_expect(wr_expect), .wr_dwell(wr_dwell), .len(len), .start(start),
    .abort(abort), .q_in(q_in), .sw_out(sw_out), .busy(busy), .done(done),
    .err(err), .err_step(err_step)
  );

  // stand-in for the 4-state machine: Q follows sw one clock later
  logic [1:0] q_reg = 2'b00;
  logic       force_en = 1'b0;
  always @(posedge clk) q_reg <= sw_out;
  assign q_in = (force_en && sw_out == 2'b11) ? 2'b00 : q_reg;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  typedef struct {
    int         kind;
    int         c;
    logic [1:0] sw;
    logic       e;
    logic [1:0] es;
  } sb_t;
  sb_t sbq[$];

  // bench copy of the program and expected sequencer situation
  logic [1:0] m_sw [4];
  logic [1:0] m_exp[4];
  int         m_dw [4];
  logic [1:0] sw_track = 2'b00;
  int         idle_from = 0;
  int         last_acc  = 0;

  task automatic predict_run(input int acc, input logic [1:0] l, input logic frc);
    int         a;
    logic       e;
    logic [1:0] es, prev, qs;
    a = acc; e = 1'b0; es = 2'b00; prev = sw_track;
    sbq.push_back('{K_ACC, acc, 2'b00, 1'b0, 2'b00});
    for (int i = 0; i <= int'(l); i++) begin
      sbq.push_back('{K_SW, a + 1, m_sw[i], 1'b0, 2'b00});
      qs = (m_dw[i] == 0) ? prev : m_sw[i];
      if (frc && m_sw[i] == 2'b11) qs = 2'b00;
      if (qs != m_exp[i] && !e) begin
        e  = 1'b1;
        es = i[1:0];
      end
      prev = m_sw[i];
      a    = a + m_dw[i] + 2;
    end
    sbq.push_back('{K_DONE, a, 2'b00, e, es});
    sw_track  = prev;
    idle_from = a;
  endtask

  sb_t  mon_e;
  logic mon_done_ok;
  always @(negedge clk) begin
    mon_done_ok = 1'b0;
    while (sbq.size() > 0 && sbq[0].c <= cyc) begin
      mon_e = sbq.pop_front();
      if (mon_e.c < cyc) begin
        check("sb_missed_cycle", cyc, mon_e.c);
      end else if (mon_e.kind == K_ACC) begin
        check("busy_on_accept", busy, 1'b1);
        check("err_cleared_on_accept", err, 1'b0);
      end else if (mon_e.kind == K_SW) begin
        check("sw_out_step", sw_out, mon_e.sw);
      end else begin
        mon_done_ok = 1'b1;
        check("done_pulse", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("err_at_done", err, mon_e.e);
        check("err_step_at_done", err_step, mon_e.es);
      end
    end
    if (done === 1'b1 && !mon_done_ok) check("done_unexpected", done, 1'b0);
  end

  task automatic step_clk();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step_clk();
  endtask

  task automatic write_step(input logic [1:0] a, input logic [1:0] s, input logic [1:0] x, input int d);
    wr_en = 1'b1; wr_addr = a; wr_sw = s; wr_expect = x; wr_dwell = d[7:0];
    step_clk();
    wr_en = 1'b0;
    m_sw[a] = s; m_exp[a] = x; m_dw[a] = d;
  endtask

  task automatic load_p1();
    write_step(2'd0, 2'b01, 2'b01, 2);
    write_step(2'd1, 2'b10, 2'b10, 2);
    write_step(2'd2, 2'b11, 2'b11, 3);
    write_step(2'd3, 2'b00, 2'b00, 1);
  endtask

  task automatic start_pulse(input int hold, input logic [1:0] l, input logic frc);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; len = l;
      if (cyc >= idle_from) begin
        last_acc = cyc + 1;
        predict_run(cyc + 1, l, frc);
      end
      step_clk();
    end
    start = 1'b0;
  endtask

  task automatic flush_from(input int c);
    while (sbq.size() > 0 && sbq[sbq.size()-1].c >= c) void'(sbq.pop_back());
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((sbq.size() > 0 || cyc < idle_from) && budget < 500) begin
      step_clk();
      budget++;
    end
    check("wait_idle_pending", sbq.size(), 0);
    step_clk(); step_clk();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    wr_addr = 2'd0; wr_sw = 2'b00; wr_expect = 2'b00; wr_dwell = 8'd0; len = 2'd0;
    for (int i = 0; i < 4; i++) begin m_sw[i] = 2'b00; m_exp[i] = 2'b00; m_dw[i] = 0; end
    step_clk(); step_clk();
    reset = 1'b0;
    check("rst_sw_out", sw_out, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_step", err_step, 2'b00);
    idle_from = cyc;

    // matching run: done 16 cycles after first APPLY
    load_p1();
    start_pulse(1, 2'd3, 1'b0);
    wait_idle();

    // step 2 forced to 00: first mismatch is step 2, run still completes
    force_en = 1'b1;
    start_pulse(1, 2'd3, 1'b1);
    wait_idle();
    force_en = 1'b0;
    start_pulse(1, 2'd3, 1'b0);
    wait_idle();

    // single zero-dwell step: CHECK sees the pre-transition Q
    write_step(2'd0, 2'b10, 2'b00, 0);
    start_pulse(1, 2'd0, 1'b0);
    wait_idle();
    write_step(2'd0, 2'b01, 2'b01, 2);

    // abort in step 1 DWELL, with a write attempted mid-run
    start_pulse(1, 2'd3, 1'b0);
    wait_cyc(last_acc + 2);
    wr_en = 1'b1; wr_addr = 2'd1; wr_sw = 2'b00; wr_expect = 2'b11; wr_dwell = 8'd5;
    step_clk();
    wr_en = 1'b0;
    wait_cyc(last_acc + 5);
    abort = 1'b1;
    flush_from(last_acc + 6);
    step_clk();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sw_hold", sw_out, 2'b10);
    idle_from = cyc; sw_track = 2'b10;
    step_clk();
    check("abort_sw_still_held", sw_out, 2'b10);
    start_pulse(1, 2'd3, 1'b0);
    wait_idle();

    // reset mid step 2 DWELL wipes state and program
    start_pulse(1, 2'd3, 1'b0);
    wait_cyc(last_acc + 10);
    reset = 1'b1;
    flush_from(last_acc + 11);
    step_clk();
    reset = 1'b0;
    check("midrst_sw_out", sw_out, 2'b00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_err_step", err_step, 2'b00);
    for (int i = 0; i < 4; i++) begin m_sw[i] = 2'b00; m_exp[i] = 2'b00; m_dw[i] = 0; end
    idle_from = cyc; sw_track = 2'b00;
    start_pulse(1, 2'd3, 1'b0);
    wait_idle();

    // start held 3 cycles, then re-asserted in the done cycle
    load_p1();
    start_pulse(3, 2'd3, 1'b0);
    wait_cyc(idle_from);
    start_pulse(1, 2'd3, 1'b0);
    wait_idle();
    repeat (5) step_clk();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
